// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - multi-cycle execution sequencer for the 8x8-bit register file
//
// Accepts one instruction over a valid/ready handshake, reads its operands
// through asel/bsel, computes the result, and writes it back through
// csel/cin/cload. ALU ops take one EXEC cycle; MUL is a shift-add loop over
// WIDTH cycles.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   instr_valid/ready instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2/imm  instruction fields, latched on accept
//   asel, bsel        register-file read selects (latched rs1/rs2)
//   aout, bout        register-file read data (combinational)
//   csel, cin, cload  register-file write port (latched rd, result, WB strobe)
//   busy, done        not-IDLE; one-cycle WB pulse
//   flag_z, flag_c    registered status flags
module exec_unit #(
  parameter int WIDTH = 8,
  parameter int SELW  = 4,
  parameter int NREG  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [SELW-1:0]  instr_rd,
  input  logic [SELW-1:0]  instr_rs1,
  input  logic [SELW-1:0]  instr_rs2,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [SELW-1:0]  asel,
  output logic [SELW-1:0]  bsel,
  input  logic [WIDTH-1:0] aout,
  input  logic [WIDTH-1:0] bout,
  output logic [SELW-1:0]  csel,
  output logic [WIDTH-1:0] cin,
  output logic             cload,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MOVI = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;

  state_t             state, state_nx;
  logic [3:0]         op_q;
  logic [SELW-1:0]    rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0]   imm_q, opa, opb, res_q;
  logic               res_c;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH:0]     alu_full;
  logic               alu_c;
  logic               mul_last, upd_flags, writes;

  // Ops above CMP are NOPs and leave the flags alone; CMP and rd beyond the
  // implemented registers still update flags but never strobe cload.
  assign upd_flags = (op_q <= OP_CMP);
  assign writes    = (op_q < OP_CMP) && (rd_q < SELW'(NREG));
  assign mul_last  = (cnt == CNTW'(WIDTH - 1));

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_WB);
  assign cload       = (state == S_WB) && writes;
  assign asel        = rs1_q;
  assign bsel        = rs2_q;
  assign csel        = rd_q;
  assign cin         = res_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (instr_valid) state_nx = S_READ;
      S_READ:  state_nx = S_EXEC;
      S_EXEC:  state_nx = (op_q == OP_MUL) ? S_MUL : S_WB;
      S_MUL:   if (mul_last) state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The extra top bit of alu_full is carry-out for adds and borrow for
  // subtracts (the zero-extended difference goes negative exactly when a<b).
  always_comb begin
    alu_full = '0;
    alu_c    = 1'b0;
    case (op_q)
      OP_ADD:         begin alu_full = {1'b0, opa} + {1'b0, opb};   alu_c = alu_full[WIDTH]; end
      OP_SUB, OP_CMP: begin alu_full = {1'b0, opa} - {1'b0, opb};   alu_c = alu_full[WIDTH]; end
      OP_AND:         alu_full = {1'b0, opa & opb};
      OP_OR:          alu_full = {1'b0, opa | opb};
      OP_XOR:         alu_full = {1'b0, opa ^ opb};
      OP_SHL:         begin alu_full = {1'b0, opa << 1}; alu_c = opa[WIDTH-1]; end
      OP_SHR:         begin alu_full = {1'b0, opa >> 1}; alu_c = opa[0]; end
      OP_MOVI:        alu_full = {1'b0, imm_q};
      OP_ADDI:        begin alu_full = {1'b0, opa} + {1'b0, imm_q}; alu_c = alu_full[WIDTH]; end
      default:        alu_full = '0;
    endcase
  end

  assign acc_nx = acc + (opb[cnt] ? ({{WIDTH{1'b0}}, opa} << cnt) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      opa    <= '0;
      opb    <= '0;
      res_q  <= '0;
      res_c  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (instr_valid) begin
          op_q  <= instr_op;
          rd_q  <= instr_rd;
          rs1_q <= instr_rs1;
          rs2_q <= instr_rs2;
          imm_q <= instr_imm;
        end
        S_READ: begin
          opa <= aout;
          opb <= bout;
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            res_q <= alu_full[WIDTH-1:0];
            res_c <= alu_c;
          end
        end
        S_MUL: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          // The final partial product is folded in directly so WB sees it.
          if (mul_last) begin
            res_q <= acc_nx[WIDTH-1:0];
            res_c <= |acc_nx[2*WIDTH-1:WIDTH];
          end
        end
        S_WB: if (upd_flags) begin
          flag_z <= (res_q == '0);
          flag_c <= res_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed self-checking bench for exec_unit with a register-file model
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op, instr_rd, instr_rs1, instr_rs2;
  logic [7:0] instr_imm;
  logic [3:0] asel, bsel, csel;
  logic [7:0] aout, bout, cin;
  logic       cload, busy, done, flag_z, flag_c;

  int vec  = 0;
  int errs = 0;
  int oob_writes = 0;

  logic [7:0] rf [0:7];

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(8), .SELW(4), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .asel(asel), .bsel(bsel), .aout(aout), .bout(bout),
    .csel(csel), .cin(cin), .cload(cload),
    .busy(busy), .done(done), .flag_z(flag_z), .flag_c(flag_c)
  );

  assign aout = (asel < 4'd8) ? rf[asel[2:0]] : 8'h00;
  assign bout = (bsel < 4'd8) ? rf[bsel[2:0]] : 8'h00;

  always @(posedge clk) begin
    if (cload) begin
      if (csel < 4'd8) rf[csel[2:0]] <= cin;
      else oob_writes <= oob_writes + 1;
    end
  end

  typedef struct {
    logic [3:0] op, rd, rs1, rs2;
    logic [7:0] imm;
    int         cl;
    logic [7:0] res;
    logic       z, c;
  } alu_vec_t;

  // Issue one instruction and follow it to its done pulse. lat is the number
  // of cycles from the accept edge to the WB cycle (0 if done never came).
  task automatic exec_op(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [7:0] imm,
                         output int lat, output int ncl, output logic [7:0] wcin,
                         output logic [3:0] wcsel, output logic z, output logic c,
                         output logic rdy);
    lat = 0; ncl = 0; wcin = 8'h00; wcsel = 4'h0;
    @(negedge clk);
    rdy = instr_ready;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (cload) begin ncl++; wcin = cin; wcsel = csel; end
      if (done) begin lat = k; break; end
    end
    @(posedge clk);
    #1;
    z = flag_z; c = flag_c;
  endtask

  task automatic test_reset();
    vec++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", instr_ready); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", done); end
    vec++; if (cload !== 1'b0) begin errs++; $display("FAIL rst_cload got %b want 0", cload); end
    vec++; if ({flag_z, flag_c} !== 2'b00) begin errs++; $display("FAIL rst_flags got %b want 00", {flag_z, flag_c}); end
    vec++; if ({asel, bsel, csel} !== 12'h000) begin errs++; $display("FAIL rst_sel got %h want 000", {asel, bsel, csel}); end
    vec++; if (cin !== 8'h00) begin errs++; $display("FAIL rst_cin got %h want 00", cin); end
  endtask

  task automatic test_alu();
    alu_vec_t   t [13];
    int         lat, ncl;
    logic [7:0] wcin;
    logic [3:0] wcsel;
    logic       z, c, rdy;
    t[0]  = '{4'd7,  4'd1, 4'd0, 4'd0, 8'h5A, 1, 8'h5A, 1'b0, 1'b0};
    t[1]  = '{4'd7,  4'd2, 4'd0, 4'd0, 8'hA6, 1, 8'hA6, 1'b0, 1'b0};
    t[2]  = '{4'd0,  4'd3, 4'd1, 4'd2, 8'h00, 1, 8'h00, 1'b1, 1'b1};
    t[3]  = '{4'd1,  4'd4, 4'd1, 4'd2, 8'h00, 1, 8'hB4, 1'b0, 1'b1};
    t[4]  = '{4'd12, 4'd6, 4'd1, 4'd2, 8'h00, 0, 8'h00, 1'b0, 1'b1};
    t[5]  = '{4'd10, 4'd0, 4'd1, 4'd1, 8'h00, 0, 8'h00, 1'b1, 1'b0};
    t[6]  = '{4'd2,  4'd6, 4'd1, 4'd2, 8'h00, 1, 8'h02, 1'b0, 1'b0};
    t[7]  = '{4'd3,  4'd6, 4'd1, 4'd2, 8'h00, 1, 8'hFE, 1'b0, 1'b0};
    t[8]  = '{4'd4,  4'd6, 4'd1, 4'd2, 8'h00, 1, 8'hFC, 1'b0, 1'b0};
    t[9]  = '{4'd5,  4'd6, 4'd2, 4'd0, 8'h00, 1, 8'h4C, 1'b0, 1'b1};
    t[10] = '{4'd6,  4'd6, 4'd1, 4'd0, 8'h00, 1, 8'h2D, 1'b0, 1'b0};
    t[11] = '{4'd6,  4'd7, 4'd6, 4'd0, 8'h00, 1, 8'h16, 1'b0, 1'b1};
    t[12] = '{4'd8,  4'd6, 4'd2, 4'd0, 8'h5A, 1, 8'h00, 1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      exec_op(t[i].op, t[i].rd, t[i].rs1, t[i].rs2, t[i].imm, lat, ncl, wcin, wcsel, z, c, rdy);
      vec++; if (rdy !== 1'b1) begin errs++; $display("FAIL alu%0d_ready got %b want 1", i, rdy); end
      vec++; if (lat !== 3) begin errs++; $display("FAIL alu%0d_latency got %0d want 3", i, lat); end
      vec++; if (ncl !== t[i].cl) begin errs++; $display("FAIL alu%0d_cloads got %0d want %0d", i, ncl, t[i].cl); end
      if (t[i].cl == 1) begin
        vec++; if (wcin !== t[i].res) begin errs++; $display("FAIL alu%0d_cin got %h want %h", i, wcin, t[i].res); end
        vec++; if (wcsel !== t[i].rd) begin errs++; $display("FAIL alu%0d_csel got %h want %h", i, wcsel, t[i].rd); end
      end
      vec++; if ({z, c} !== {t[i].z, t[i].c}) begin errs++; $display("FAIL alu%0d_flags got %b want %b", i, {z, c}, {t[i].z, t[i].c}); end
    end
    vec++; if (rf[7] !== 8'h16) begin errs++; $display("FAIL alu_rf7 got %h want 16", rf[7]); end
    vec++; if (rf[4] !== 8'hB4) begin errs++; $display("FAIL alu_rf4 got %h want b4", rf[4]); end
  endtask

  task automatic test_mul();
    int         lat, ncl;
    logic [7:0] wcin;
    logic [3:0] wcsel;
    logic       z, c, rdy;
    exec_op(4'd7, 4'd6, 4'd0, 4'd0, 8'h0F, lat, ncl, wcin, wcsel, z, c, rdy);
    exec_op(4'd7, 4'd7, 4'd0, 4'd0, 8'h11, lat, ncl, wcin, wcsel, z, c, rdy);
    exec_op(4'd9, 4'd5, 4'd6, 4'd7, 8'h00, lat, ncl, wcin, wcsel, z, c, rdy);
    vec++; if (lat !== 11) begin errs++; $display("FAIL mul1_latency got %0d want 11", lat); end
    vec++; if (ncl !== 1) begin errs++; $display("FAIL mul1_cloads got %0d want 1", ncl); end
    vec++; if (wcsel !== 4'd5) begin errs++; $display("FAIL mul1_csel got %h want 5", wcsel); end
    vec++; if (wcin !== 8'hFF) begin errs++; $display("FAIL mul1_cin got %h want ff", wcin); end
    vec++; if ({z, c} !== 2'b00) begin errs++; $display("FAIL mul1_flags got %b want 00", {z, c}); end
    vec++; if (rf[5] !== 8'hFF) begin errs++; $display("FAIL mul1_rf5 got %h want ff", rf[5]); end
    exec_op(4'd7, 4'd6, 4'd0, 4'd0, 8'h10, lat, ncl, wcin, wcsel, z, c, rdy);
    exec_op(4'd9, 4'd4, 4'd6, 4'd6, 8'h00, lat, ncl, wcin, wcsel, z, c, rdy);
    vec++; if (lat !== 11) begin errs++; $display("FAIL mul2_latency got %0d want 11", lat); end
    vec++; if (wcin !== 8'h00 || ncl !== 1) begin errs++; $display("FAIL mul2_cin got %h/%0d want 00/1", wcin, ncl); end
    vec++; if ({z, c} !== 2'b11) begin errs++; $display("FAIL mul2_flags got %b want 11", {z, c}); end
  endtask

  task automatic test_reset_midstream();
    int         lat, ncl;
    logic [7:0] wcin;
    logic [3:0] wcsel;
    logic       z, c, rdy;
    exec_op(4'd1, 4'd4, 4'd1, 4'd2, 8'h00, lat, ncl, wcin, wcsel, z, c, rdy);
    vec++; if (wcin !== 8'hB4 || c !== 1'b1) begin errs++; $display("FAIL mid_pre got %h/%b want b4/1", wcin, c); end
    ncl = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd4; instr_rd = 4'd3; instr_rs1 = 4'd1; instr_rs2 = 4'd2;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0; if (cload) ncl++;
    @(negedge clk); rst = 1'b1; if (cload) ncl++;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    vec++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL mid_ready got %b want 1", instr_ready); end
    vec++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL mid_busy_done got %b%b want 00", busy, done); end
    vec++; if ({flag_z, flag_c} !== 2'b00) begin errs++; $display("FAIL mid_flags got %b want 00", {flag_z, flag_c}); end
    vec++; if (cin !== 8'h00) begin errs++; $display("FAIL mid_cin got %h want 00", cin); end
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (cload) ncl++; end
    vec++; if (ncl !== 0) begin errs++; $display("FAIL mid_cload got %0d want 0", ncl); end
    vec++; if (rf[3] !== 8'h00) begin errs++; $display("FAIL mid_rf3 got %h want 00", rf[3]); end
  endtask

  task automatic test_rd_oob();
    int         lat, ncl;
    logic [7:0] wcin;
    logic [3:0] wcsel;
    logic       z, c, rdy;
    exec_op(4'd7, 4'd9, 4'd0, 4'd0, 8'h00, lat, ncl, wcin, wcsel, z, c, rdy);
    vec++; if (lat !== 3) begin errs++; $display("FAIL oob_done got %0d want 3", lat); end
    vec++; if (ncl !== 0 || oob_writes !== 0) begin errs++; $display("FAIL oob_cload got %0d/%0d want 0/0", ncl, oob_writes); end
    vec++; if ({z, c} !== 2'b10) begin errs++; $display("FAIL oob_flags got %b want 10", {z, c}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] t_op [3], t_rd [3], t_rs1 [3], t_rs2 [3];
    logic [7:0] t_imm [3];
    int         idx, ncl, bad, acc_at [3];
    logic       take;
    t_op  = '{4'd7, 4'd7, 4'd0};
    t_rd  = '{4'd1, 4'd2, 4'd3};
    t_rs1 = '{4'd0, 4'd0, 4'd1};
    t_rs2 = '{4'd0, 4'd0, 4'd2};
    t_imm = '{8'h11, 8'h22, 8'h00};
    idx = 0; ncl = 0; bad = 0;
    acc_at = '{0, 0, 0};
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (cload) ncl++;
      if (instr_ready && busy) bad++;
      if (idx < 3) begin
        instr_valid = 1'b1; instr_op = t_op[idx]; instr_rd = t_rd[idx];
        instr_rs1 = t_rs1[idx]; instr_rs2 = t_rs2[idx]; instr_imm = t_imm[idx];
      end else begin
        instr_valid = 1'b0;
      end
      take = instr_valid && instr_ready;
      @(posedge clk);
      if (take && idx < 3) begin acc_at[idx] = cyc; idx++; end
    end
    vec++; if (idx !== 3) begin errs++; $display("FAIL b2b_accepts got %0d want 3", idx); end
    vec++; if (ncl !== 3) begin errs++; $display("FAIL b2b_cloads got %0d want 3", ncl); end
    vec++; if (acc_at[1] - acc_at[0] !== 4 || acc_at[2] - acc_at[1] !== 4) begin
      errs++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", acc_at[1] - acc_at[0], acc_at[2] - acc_at[1]); end
    vec++; if (bad !== 0) begin errs++; $display("FAIL b2b_ready_busy got %0d want 0", bad); end
    vec++; if (rf[3] !== 8'h33) begin errs++; $display("FAIL b2b_rf3 got %h want 33", rf[3]); end
  endtask

  task automatic test_mul_reset();
    int ncl, ndone;
    ncl = 0; ndone = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd9; instr_rd = 4'd5; instr_rs1 = 4'd6; instr_rs2 = 4'd6;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (k == 7) rst = 1'b1;
      if (k == 8) begin
        rst = 1'b0;
        vec++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin
          errs++; $display("FAIL mulrst_idle got ready=%b busy=%b want 1/0", instr_ready, busy); end
      end
      if (cload) ncl++;
      if (done) ndone++;
    end
    vec++; if (ncl !== 0 || ndone !== 0) begin errs++; $display("FAIL mulrst_cload got %0d/%0d want 0/0", ncl, ndone); end
    vec++; if (rf[5] !== 8'hFF) begin errs++; $display("FAIL mulrst_rf5 got %h want ff", rf[5]); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rst = 1'b1; instr_valid = 1'b0; instr_op = 4'h0; instr_rd = 4'h0;
    instr_rs1 = 4'h0; instr_rs2 = 4'h0; instr_imm = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_alu();
    test_mul();
    test_reset_midstream();
    test_rd_oob();
    test_back_to_back();
    test_mul_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
